// File: rtl/cp2_issue_ctrl_pkg.sv
// cp2 issue controller shared encodings.
// Request kinds, FSM states and default exception-code width.
package cp2_issue_ctrl_pkg;

    localparam int EXCCODE_W_DEF = 4;

    typedef enum logic [1:0] {
        KIND_IR = 2'b00,
        KIND_TS = 2'b01,
        KIND_FS = 2'b10,
        KIND_AS = 2'b11
    } kind_e;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        SEND      = 3'd3,
        RECV      = 3'd4,
        DONE      = 3'd5
    } state_e;

endpackage

// File: rtl/cp2_issue_ctrl_exc_latch.sv
// cp2 exception latch: pending flag, latest code, optional overrun count.
// Overrun counter present only when CP2_EXC_OVERRUN_EN is defined.
module cp2_exc_latch
    import cp2_issue_ctrl_pkg::*;
#(
    parameter int EXCCODE_W = EXCCODE_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_exc,
    input  logic                 i_excs,
    input  logic [EXCCODE_W-1:0] i_code,
    input  logic                 i_ack,
    output logic                 o_pending,
    output logic [EXCCODE_W-1:0] o_code
`ifdef CP2_EXC_OVERRUN_EN
    ,
    output logic [7:0]           o_overrun_cnt
`endif
);

    logic                 r_pending;
    logic [EXCCODE_W-1:0] r_code;
    logic                 w_hit;

    assign w_hit = i_exc & i_excs;

    // A new exception wins over a coincident ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= 1'b0;
            r_code    <= '0;
        end else begin
            r_pending <= w_hit | (r_pending & ~i_ack);
            if (w_hit) begin
                r_code <= i_code;
            end
        end
    end

    assign o_pending = r_pending;
    assign o_code    = r_code;

`ifdef CP2_EXC_OVERRUN_EN
    logic [7:0] r_ovr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovr <= '0;
        end else if (i_ack) begin
            r_ovr <= '0;
        end else if (w_hit && r_pending && (r_ovr != 8'hFF)) begin
            r_ovr <= r_ovr + 8'd1;
        end
    end

    assign o_overrun_cnt = r_ovr;
`endif

endmodule

// File: rtl/cp2_issue_ctrl.sv
// CPU-side issue/handshake controller in front of the cp2 coprocessor.
// Optional exception overrun counter: define CP2_EXC_OVERRUN_EN.
module cp2_issue_ctrl
    import cp2_issue_ctrl_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int EXCCODE_W = EXCCODE_W_DEF,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_kind,
    input  logic [DATA_W-1:0]    req_ir,
    input  logic [DATA_W-1:0]    req_wdata,
    output logic                 resp_valid,
    output logic [DATA_W-1:0]    resp_rdata,
    output logic                 resp_timeout,
    output logic                 cp2_irenable_0,
    output logic [DATA_W-1:0]    cp2_ir_0,
    output logic                 cp2_ts_0,
    output logic                 cp2_fs_0,
    output logic                 cp2_as_0,
    input  logic                 cp2_tbusy_0,
    input  logic                 cp2_fbusy_0,
    input  logic                 cp2_abusy_0,
    output logic                 cp2_tds_0,
    output logic [DATA_W-1:0]    cp2_tdata_0,
    input  logic                 cp2_fds_0,
    input  logic [DATA_W-1:0]    cp2_fdata_0,
    input  logic                 cp2_excs_0,
    input  logic                 cp2_exc_0,
    input  logic [EXCCODE_W-1:0] cp2_exccode_0,
    output logic                 irq_pending,
    output logic [EXCCODE_W-1:0] irq_code,
    input  logic                 irq_ack
`ifdef CP2_EXC_OVERRUN_EN
    ,
    output logic [7:0]           exc_overrun_cnt
`endif
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] W_TO = CNT_W'(TIMEOUT);

    state_e              r_state, w_nxt;
    kind_e               r_kind, w_req_kind;
    logic [DATA_W-1:0]   r_wdata;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt, w_cnt_inc;
    logic                w_busy, w_expire, w_to_nxt, w_cap;

    logic                r_ready, r_rv, r_to;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_iren, r_ts, r_fs, r_as, r_tds;
    logic [DATA_W-1:0]   r_ir, r_tdata;

    assign w_req_kind = kind_e'(req_kind);
    assign w_cnt_inc  = r_cnt + 1'b1;
    assign w_expire   = (TIMEOUT != 0) && (w_cnt_inc == W_TO);

    always_comb begin
        w_busy = 1'b0;
        case (r_kind)
            KIND_TS: w_busy = cp2_tbusy_0;
            KIND_FS: w_busy = cp2_fbusy_0;
            KIND_AS: w_busy = cp2_abusy_0;
            default: w_busy = 1'b0;
        endcase
    end

    always_comb begin
        w_nxt     = r_state;
        w_cnt_nxt = r_cnt;
        w_to_nxt  = 1'b0;
        w_cap     = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) w_nxt = ISSUE;
            end
            ISSUE: begin
                w_cnt_nxt = '0;
                w_nxt     = (r_kind == KIND_IR) ? DONE : WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!w_busy) begin
                    // Counter restarts so RECV gets its own full budget.
                    w_cnt_nxt = '0;
                    case (r_kind)
                        KIND_TS: w_nxt = SEND;
                        KIND_FS: w_nxt = RECV;
                        default: w_nxt = DONE;
                    endcase
                end else if (w_expire) begin
                    w_nxt    = DONE;
                    w_to_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            SEND: w_nxt = DONE;
            RECV: begin
                if (cp2_fds_0) begin
                    w_cap = 1'b1;
                    w_nxt = DONE;
                end else if (w_expire) begin
                    w_nxt    = DONE;
                    w_to_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            DONE:    w_nxt = IDLE;
            default: w_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_kind  <= KIND_IR;
            r_wdata <= '0;
            r_cnt   <= '0;
            r_ready <= 1'b1;
            r_rv    <= 1'b0;
            r_to    <= 1'b0;
            r_rdata <= '0;
            r_iren  <= 1'b0;
            r_ir    <= '0;
            r_ts    <= 1'b0;
            r_fs    <= 1'b0;
            r_as    <= 1'b0;
            r_tds   <= 1'b0;
            r_tdata <= '0;
        end else begin
            r_state <= w_nxt;
            r_cnt   <= w_cnt_nxt;
            if ((r_state == IDLE) && req_valid) begin
                r_kind  <= w_req_kind;
                r_wdata <= req_wdata;
            end
            r_ready <= (w_nxt == IDLE);
            r_rv    <= (w_nxt == DONE);
            r_to    <= w_to_nxt;
            if (w_cap) r_rdata <= cp2_fdata_0;
            r_iren  <= (w_nxt == ISSUE);
            r_ir    <= (w_nxt == ISSUE) ? req_ir : '0;
            r_ts    <= (w_nxt == ISSUE) && (w_req_kind == KIND_TS);
            r_fs    <= (w_nxt == ISSUE) && (w_req_kind == KIND_FS);
            r_as    <= (w_nxt == ISSUE) && (w_req_kind == KIND_AS);
            r_tds   <= (w_nxt == SEND);
            r_tdata <= (w_nxt == SEND) ? r_wdata : '0;
        end
    end

    assign req_ready      = r_ready;
    assign resp_valid     = r_rv;
    assign resp_timeout   = r_to;
    assign resp_rdata     = r_rdata;
    assign cp2_irenable_0 = r_iren;
    assign cp2_ir_0       = r_ir;
    assign cp2_ts_0       = r_ts;
    assign cp2_fs_0       = r_fs;
    assign cp2_as_0       = r_as;
    assign cp2_tds_0      = r_tds;
    assign cp2_tdata_0    = r_tdata;

    cp2_exc_latch #(
        .EXCCODE_W(EXCCODE_W)
    ) u_exc (
        .clk          (clk),
        .rst          (rst),
        .i_exc        (cp2_exc_0),
        .i_excs       (cp2_excs_0),
        .i_code       (cp2_exccode_0),
        .i_ack        (irq_ack),
        .o_pending    (irq_pending),
        .o_code       (irq_code)
`ifdef CP2_EXC_OVERRUN_EN
        ,
        .o_overrun_cnt(exc_overrun_cnt)
`endif
    );

endmodule

// File: tb/tb_cp2_issue_ctrl.sv
// Self-checking bench for cp2_issue_ctrl (TIMEOUT=8).
// Overrun checks included when CP2_EXC_OVERRUN_EN is defined.
module tb_cp2_issue_ctrl;
    import cp2_issue_ctrl_pkg::*;

    localparam int DW = 32;
    localparam int EW = 4;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_kind = 2'b00;
    logic [DW-1:0] req_ir = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          resp_valid;
    logic [DW-1:0] resp_rdata;
    logic          resp_timeout;
    logic          cp2_irenable_0;
    logic [DW-1:0] cp2_ir_0;
    logic          cp2_ts_0, cp2_fs_0, cp2_as_0;
    logic          cp2_tbusy_0 = 1'b0;
    logic          cp2_fbusy_0 = 1'b0;
    logic          cp2_abusy_0 = 1'b0;
    logic          cp2_tds_0;
    logic [DW-1:0] cp2_tdata_0;
    logic          cp2_fds_0 = 1'b0;
    logic [DW-1:0] cp2_fdata_0 = '0;
    logic          cp2_excs_0 = 1'b0;
    logic          cp2_exc_0 = 1'b0;
    logic [EW-1:0] cp2_exccode_0 = '0;
    logic          irq_pending;
    logic [EW-1:0] irq_code;
    logic          irq_ack = 1'b0;
`ifdef CP2_EXC_OVERRUN_EN
    logic [7:0]    exc_overrun_cnt;
`endif

    always #5 clk = ~clk;

    cp2_issue_ctrl #(
        .DATA_W(DW), .EXCCODE_W(EW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_kind(req_kind), .req_ir(req_ir), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_timeout(resp_timeout),
        .cp2_irenable_0(cp2_irenable_0), .cp2_ir_0(cp2_ir_0),
        .cp2_ts_0(cp2_ts_0), .cp2_fs_0(cp2_fs_0), .cp2_as_0(cp2_as_0),
        .cp2_tbusy_0(cp2_tbusy_0), .cp2_fbusy_0(cp2_fbusy_0),
        .cp2_abusy_0(cp2_abusy_0),
        .cp2_tds_0(cp2_tds_0), .cp2_tdata_0(cp2_tdata_0),
        .cp2_fds_0(cp2_fds_0), .cp2_fdata_0(cp2_fdata_0),
        .cp2_excs_0(cp2_excs_0), .cp2_exc_0(cp2_exc_0),
        .cp2_exccode_0(cp2_exccode_0),
        .irq_pending(irq_pending), .irq_code(irq_code), .irq_ack(irq_ack)
`ifdef CP2_EXC_OVERRUN_EN
        , .exc_overrun_cnt(exc_overrun_cnt)
`endif
    );

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          to;
    } resp_t;

    resp_t         sb_q[$];
    int            n_checks = 0;
    int            n_fails  = 0;
    int            n_resp   = 0;
    logic [DW-1:0] exp_rdata = '0;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sb_push(logic [DW-1:0] rd, logic to);
        resp_t e;
        e.rdata = rd;
        e.to    = to;
        sb_q.push_back(e);
    endtask

    task automatic issue(logic [1:0] k, logic [DW-1:0] ir, logic [DW-1:0] wd);
        check("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_kind  = k;
        req_ir    = ir;
        req_wdata = wd;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(string tag, int exp_lat);
        int lat = 1;
        while (!resp_valid && lat < 40) begin
            tick();
            lat++;
        end
        check(tag, lat, exp_lat);
        tick();
    endtask

    always @(negedge clk) begin
        resp_t e;
        if (resp_valid) begin
            n_resp++;
            if (sb_q.size() == 0) begin
                check("resp_unexpected", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("resp_rdata", resp_rdata, e.rdata);
                check("resp_timeout", resp_timeout, e.to);
            end
        end
        check("strobe_onehot",
              ($countones({cp2_ts_0, cp2_fs_0, cp2_as_0}) <= 1), 1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check_reset_outs(string tag);
        check({tag, "_bits"},
              {cp2_irenable_0, cp2_ts_0, cp2_fs_0, cp2_as_0, cp2_tds_0,
               resp_valid, resp_timeout, irq_pending}, 0);
        check({tag, "_ir"}, cp2_ir_0, 0);
        check({tag, "_tdata"}, cp2_tdata_0, 0);
        check({tag, "_rdata"}, resp_rdata, 0);
        check({tag, "_code"}, irq_code, 0);
        check({tag, "_ready"}, req_ready, 1);
    endtask

    initial begin
        int r0;

        tick(3);
        check_reset_outs("por");
        rst = 1'b0;
        tick();

        // to-cp2 transfer, cycle by cycle
        sb_push(exp_rdata, 1'b0);
        issue(KIND_TS, 32'h1234_0001, 32'hDEAD_BEEF);
        check("ts_iren", cp2_irenable_0, 1);
        check("ts_ir", cp2_ir_0, 32'h1234_0001);
        check("ts_strb", {cp2_ts_0, cp2_fs_0, cp2_as_0}, 3'b100);
        check("ts_ready_drop", req_ready, 0);
        tick();
        check("ts_wait_iren", {cp2_irenable_0, cp2_ts_0, cp2_tds_0}, 0);
        tick();
        check("ts_tds", cp2_tds_0, 1);
        check("ts_tdata", cp2_tdata_0, 32'hDEAD_BEEF);
        tick();
        check("ts_lat4", resp_valid, 1);
        tick();
        check("ts_after", {resp_valid, cp2_tds_0, req_ready}, 3'b001);

        // ir-only
        sb_push(exp_rdata, 1'b0);
        issue(KIND_IR, 32'h0000_0042, '0);
        check("ir_strb", {cp2_irenable_0, cp2_ts_0, cp2_fs_0, cp2_as_0},
              4'b1000);
        wait_resp("lat_ir", 2);

        // action, no busy
        sb_push(exp_rdata, 1'b0);
        issue(KIND_AS, 32'h0000_0077, '0);
        check("as_strb", {cp2_ts_0, cp2_fs_0, cp2_as_0}, 3'b001);
        wait_resp("lat_as", 3);

        // from-cp2, fbusy 5 cycles then fds two RECV cycles later
        cp2_fbusy_0 = 1'b1;
        exp_rdata = 32'h0000_00A5;
        sb_push(exp_rdata, 1'b0);
        r0 = n_resp;
        issue(KIND_FS, 32'h0000_0099, '0);
        check("fs_strb", {cp2_ts_0, cp2_fs_0, cp2_as_0}, 3'b010);
        tick(6);
        cp2_fbusy_0 = 1'b0;
        tick(2);
        cp2_fds_0   = 1'b1;
        cp2_fdata_0 = 32'h0000_00A5;
        tick();
        cp2_fds_0   = 1'b0;
        cp2_fdata_0 = 32'hFFFF_FFFF;
        check("fs_done", resp_valid, 1);
        tick(3);
        check("fs_once", n_resp - r0, 1);

        // rdata holds across a transfer that captures nothing
        sb_push(exp_rdata, 1'b0);
        issue(KIND_IR, 32'h0000_0001, '0);
        wait_resp("lat_ir2", 2);

        // fds already high on the first RECV cycle
        cp2_fds_0   = 1'b1;
        cp2_fdata_0 = 32'h0000_005A;
        exp_rdata   = 32'h0000_005A;
        sb_push(exp_rdata, 1'b0);
        issue(KIND_FS, 32'h0000_0002, '0);
        wait_resp("lat_fs_early", 4);
        cp2_fds_0 = 1'b0;

        // abusy stuck: timeout after TO wait cycles
        cp2_abusy_0 = 1'b1;
        sb_push(exp_rdata, 1'b1);
        issue(KIND_AS, 32'h0000_0003, '0);
        wait_resp("lat_timeout", TO + 2);
        cp2_abusy_0 = 1'b0;
        check("timeout_clear", resp_timeout, 0);

        // reset held 3 cycles mid-SEND
        r0 = n_resp;
        issue(KIND_TS, 32'h0000_0004, 32'hCAFE_F00D);
        tick(2);
        check("pre_rst_tds", cp2_tds_0, 1);
        rst = 1'b1;
        tick(3);
        exp_rdata = '0;
        check_reset_outs("mid_send_rst");
        rst = 1'b0;
        tick(3);
        check("rst_no_resp", n_resp - r0, 0);
        check("rst_ready", req_ready, 1);

        // exception latch
        cp2_excs_0 = 1'b1; cp2_exc_0 = 1'b1; cp2_exccode_0 = 4'd3;
        tick();
        cp2_exc_0 = 1'b0;
        check("exc_set", {irq_pending, irq_code}, {1'b1, 4'd3});
        cp2_exc_0 = 1'b1; cp2_exccode_0 = 4'd5; irq_ack = 1'b1;
        tick();
        cp2_exc_0 = 1'b0; irq_ack = 1'b0;
        check("exc_ack_coinc", {irq_pending, irq_code}, {1'b1, 4'd5});
        cp2_excs_0 = 1'b0; cp2_exc_0 = 1'b1; cp2_exccode_0 = 4'd7;
        tick();
        cp2_exc_0 = 1'b0;
        check("exc_masked", {irq_pending, irq_code}, {1'b1, 4'd5});
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("exc_ack", {irq_pending, irq_code}, {1'b0, 4'd5});
        cp2_excs_0 = 1'b1; cp2_exc_0 = 1'b1; cp2_exccode_0 = 4'd9;
        tick();
        cp2_exccode_0 = 4'hA;
        tick();
        cp2_exc_0 = 1'b0;
        check("exc_overwrite", {irq_pending, irq_code}, {1'b1, 4'hA});

`ifdef CP2_EXC_OVERRUN_EN
        check("ovr_one", exc_overrun_cnt, 1);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("ovr_ack0", exc_overrun_cnt, 0);
        cp2_exc_0 = 1'b1;
        tick(300);
        cp2_exc_0 = 1'b0;
        check("ovr_sat", exc_overrun_cnt, 255);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("ovr_clr", exc_overrun_cnt, 0);
`endif

        tick(2);
        check("sb_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
